// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply compute engine: FSM encoding,
// derived-size helpers and the row element slice macro.
`ifndef MATMUL_PKG_SV
`define MATMUL_PKG_SV

// Element k of a packed row: element 0 sits in the least significant bits.
`define MATMUL_ELEM(row, k, w) row[((k)+1)*(w)-1 -: (w)]

package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_LOAD,
    ST_CALC,
    ST_DONE
  } state_e;

  // Number of elements that fit in one operand row.
  function automatic int calc_max_dim(input int bus_w, input int data_w);
    return bus_w / data_w;
  endfunction

  // Index width for rows/columns; never narrower than one bit.
  function automatic int calc_aw(input int max_dim);
    return (max_dim > 1) ? $clog2(max_dim) : 1;
  endfunction

  // Width that holds a full-precision signed dot product of max_dim terms.
  function automatic int calc_full_w(input int data_w, input int max_dim);
    return 2 * data_w + $clog2(max_dim);
  endfunction

endpackage

`endif

// File: rtl/dot_product_unit.sv
// Combinational signed dot product of one A row with one gathered B column.
// Terms whose k_mask bit is clear contribute zero.
module dot_product_unit
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MAX_DIM    = 2,
  parameter int FULL_W     = calc_full_w(DATA_WIDTH, MAX_DIM)
) (
  input  logic [MAX_DIM*DATA_WIDTH-1:0] a_row,
  input  logic [MAX_DIM*DATA_WIDTH-1:0] b_col,
  input  logic [MAX_DIM-1:0]            k_mask,
  output logic signed [FULL_W-1:0]      dot
);

  logic signed [2*DATA_WIDTH-1:0] prod [MAX_DIM];

  // One signed multiplier per column position, zeroed where masked off.
  always_comb begin
    for (int k = 0; k < MAX_DIM; k++) begin
      prod[k] = '0;
      if (k_mask[k]) begin
        prod[k] = $signed(`MATMUL_ELEM(a_row, k, DATA_WIDTH)) *
                  $signed(`MATMUL_ELEM(b_col, k, DATA_WIDTH));
      end
    end
  end

  // Sign-extend every product to full precision and accumulate.
  always_comb begin
    dot = '0;
    for (int k = 0; k < MAX_DIM; k++) begin
      dot = dot + FULL_W'(prod[k]);
    end
  end

endmodule

// File: rtl/matmul_calc_unit.sv
// Matrix-multiply engine: pulses the operand banks, captures every row of A
// and B, then streams C = A*B out one element per cycle to the scratchpad.
module matmul_calc_unit
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 64,
  parameter int RES_WIDTH   = BUS_WIDTH,
  localparam int MAX_DIM    = calc_max_dim(BUS_WIDTH, DATA_WIDTH),
  localparam int AW         = calc_aw(MAX_DIM),
  localparam int FULL_W     = calc_full_w(DATA_WIDTH, MAX_DIM)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [AW-1:0]        dim_n_i,
  input  logic [AW-1:0]        dim_k_i,
  input  logic [AW-1:0]        dim_m_i,
  output logic                 op_start_o,
  output logic [AW-1:0]        op_addr_o,
  input  logic [BUS_WIDTH-1:0] a_row_i,
  input  logic [BUS_WIDTH-1:0] b_row_i,
  output logic                 res_we_o,
  output logic [2*AW-1:0]      res_addr_o,
  output logic [RES_WIDTH-1:0] res_data_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 ovf_o
);

  localparam int ROW_W = MAX_DIM * DATA_WIDTH;

  state_e state_q, state_d;

  logic [AW-1:0] dim_n_q, dim_k_q, dim_m_q;
  logic [AW-1:0] row_q, i_q, j_q;
  logic [BUS_WIDTH-1:0] buf_a_q [MAX_DIM];
  logic [BUS_WIDTH-1:0] buf_b_q [MAX_DIM];

  logic start_acc;
  logic last_row, last_elem;
  logic [ROW_W-1:0] a_sel, b_col;
  logic [MAX_DIM-1:0] k_mask;
  logic signed [FULL_W-1:0] dot;
  logic [RES_WIDTH-1:0] res_trunc;
  logic elem_ovf;

  // The banks only ever need to be pointed at row 0; they walk on their own.
  assign op_addr_o = '0;

  assign last_row  = (row_q == AW'(MAX_DIM - 1));
  assign last_elem = (i_q == dim_n_q) && (j_q == dim_m_q);
  assign a_sel     = buf_a_q[i_q][ROW_W-1:0];

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode and per-state control outputs.
  always_comb begin
    state_d    = state_q;
    op_start_o = 1'b0;
    busy_o     = 1'b1;
    done_o     = 1'b0;
    start_acc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_o = 1'b0;
        if (start_i) begin
          start_acc = 1'b1;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        op_start_o = 1'b1;
        state_d    = ST_LOAD;
      end
      ST_LOAD: begin
        if (last_row) state_d = ST_CALC;
      end
      ST_CALC: begin
        if (last_elem) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Dimensions are frozen for the whole job once a start is accepted.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      dim_n_q <= '0;
      dim_k_q <= '0;
      dim_m_q <= '0;
    end else if (start_acc) begin
      dim_n_q <= dim_n_i;
      dim_k_q <= dim_k_i;
      dim_m_q <= dim_m_i;
    end
  end

  // Row capture during LOAD and the i/j walk during CALC (j is the inner loop).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      row_q <= '0;
      i_q   <= '0;
      j_q   <= '0;
      for (int r = 0; r < MAX_DIM; r++) begin
        buf_a_q[r] <= '0;
        buf_b_q[r] <= '0;
      end
    end else begin
      unique case (state_q)
        ST_START: begin
          row_q <= '0;
          i_q   <= '0;
          j_q   <= '0;
        end
        ST_LOAD: begin
          buf_a_q[row_q] <= a_row_i;
          buf_b_q[row_q] <= b_row_i;
          row_q          <= row_q + 1'b1;
        end
        ST_CALC: begin
          if (j_q == dim_m_q) begin
            j_q <= '0;
            i_q <= i_q + 1'b1;
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gather column j of B across the captured rows and build the k mask.
  always_comb begin
    b_col  = '0;
    k_mask = '0;
    for (int k = 0; k < MAX_DIM; k++) begin
      k_mask[k] = (AW'(k) <= dim_k_q);
      `MATMUL_ELEM(b_col, k, DATA_WIDTH) = `MATMUL_ELEM(buf_b_q[k], j_q, DATA_WIDTH);
    end
  end

  dot_product_unit #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_DIM    (MAX_DIM),
    .FULL_W     (FULL_W)
  ) u_dot (
    .a_row  (a_sel),
    .b_col  (b_col),
    .k_mask (k_mask),
    .dot    (dot)
  );

  // Narrow the dot product to the scratchpad width; flag any lost magnitude.
  if (RES_WIDTH < FULL_W) begin : g_trunc
    logic [FULL_W-RES_WIDTH:0] upper;
    assign upper     = dot[FULL_W-1:RES_WIDTH-1];
    assign res_trunc = dot[RES_WIDTH-1:0];
    assign elem_ovf  = !((&upper) || !(|upper));
  end else begin : g_ext
    assign res_trunc = RES_WIDTH'(dot);
    assign elem_ovf  = 1'b0;
  end

  // Registered write port plus the sticky overflow flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_we_o   <= 1'b0;
      res_addr_o <= '0;
      res_data_o <= '0;
      ovf_o      <= 1'b0;
    end else begin
      res_we_o <= (state_q == ST_CALC);
      if (state_q == ST_CALC) begin
        res_addr_o <= {i_q, j_q};
        res_data_o <= res_trunc;
      end
      if (start_acc) begin
        ovf_o <= 1'b0;
      end else if ((state_q == ST_CALC) && elem_ovf) begin
        ovf_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_matmul_calc_unit.sv
// Scoreboard bench for matmul_calc_unit with a behavioural bank model and a
// plain-arithmetic reference for C = A*B.
module tb_matmul_calc_unit;

  localparam int DW = 32;
  localparam int BW = 64;
  localparam int MD = 2;
  localparam int AW = 1;
  localparam int RW = 64;

  logic          clk_i   = 1'b0;
  logic          rst_ni  = 1'b0;
  logic          start_i = 1'b0;
  logic [AW-1:0] dim_n_i = '0;
  logic [AW-1:0] dim_k_i = '0;
  logic [AW-1:0] dim_m_i = '0;
  logic          op_start_o;
  logic [AW-1:0] op_addr_o;
  logic [BW-1:0] a_row_i, b_row_i;
  logic          res_we_o;
  logic [2*AW-1:0] res_addr_o;
  logic [RW-1:0] res_data_o;
  logic          busy_o, done_o, ovf_o;

  logic [DW-1:0] a_mem [MD][MD];
  logic [DW-1:0] b_mem [MD][MD];
  int bank_addr = 0;

  typedef struct {
    logic [2*AW-1:0] addr;
    logic [RW-1:0]   data;
    bit              last;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  matmul_calc_unit dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .start_i    (start_i),
    .dim_n_i    (dim_n_i),
    .dim_k_i    (dim_k_i),
    .dim_m_i    (dim_m_i),
    .op_start_o (op_start_o),
    .op_addr_o  (op_addr_o),
    .a_row_i    (a_row_i),
    .b_row_i    (b_row_i),
    .res_we_o   (res_we_o),
    .res_addr_o (res_addr_o),
    .res_data_o (res_data_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .ovf_o      (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Operand bank behaviour: start resets the address, otherwise it walks.
  always @(posedge clk_i) bank_addr <= op_start_o ? 0 : (bank_addr + 1) % MD;

  assign a_row_i = {a_mem[bank_addr][1], a_mem[bank_addr][0]};
  assign b_row_i = {b_mem[bank_addr][1], b_mem[bank_addr][0]};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference: C[i][j] = sum_k A[i][k]*B[k][j] in wide signed arithmetic.
  task automatic pushExpected(input int dn, input int dk, input int dm, output bit ovf);
    logic signed [64:0] sum;
    longint p;
    exp_t e;
    ovf = 1'b0;
    for (int i = 0; i <= dn; i++) begin
      for (int j = 0; j <= dm; j++) begin
        sum = '0;
        for (int k = 0; k <= dk; k++) begin
          p = longint'($signed(a_mem[i][k])) * longint'($signed(b_mem[k][j]));
          sum = sum + 65'(p);
        end
        e.addr = {1'(i), 1'(j)};
        e.data = sum[63:0];
        e.last = (i == dn) && (j == dm);
        exp_q.push_back(e);
        if (sum[64] != sum[63]) ovf = 1'b1;
      end
    end
  endtask

  task automatic fillRandom();
    for (int r = 0; r < MD; r++) begin
      for (int c = 0; c < MD; c++) begin
        if ($urandom_range(0, 1) == 1) begin
          a_mem[r][c] = $urandom();
          b_mem[r][c] = $urandom();
        end else begin
          a_mem[r][c] = 32'($urandom_range(0, 20)) - 32'd10;
          b_mem[r][c] = 32'($urandom_range(0, 20)) - 32'd10;
        end
      end
    end
  endtask

  // Issue one job and follow it to done (or to a mid-job reset).
  task automatic applyStimulus(input int dn, input int dk, input int dm,
                               input bit early, input bit poke, input int reset_after);
    bit exp_ovf;
    bit seen;
    int cnt, writes, done_before, nm;
    nm = (dn + 1) * (dm + 1);
    pushExpected(dn, dk, dm, exp_ovf);
    if (!early) @(negedge clk_i);
    dim_n_i = AW'(dn);
    dim_k_i = AW'(dk);
    dim_m_i = AW'(dm);
    start_i = 1'b1;
    if (early) begin
      @(negedge clk_i);
      checkOutput("start_in_done_ignored", 64'(busy_o), 64'(0));
    end
    cnt = 0;
    writes = 0;
    seen = 1'b0;
    done_before = done_cnt;
    forever begin
      @(negedge clk_i);
      cnt++;
      if (cnt == 1) begin
        start_i = 1'b0;
        checkOutput("op_start", 64'(op_start_o), 64'(1));
        checkOutput("ovf_cleared_by_start", 64'(ovf_o), 64'(0));
      end
      if (poke && (cnt == 2 || cnt == MD + 3)) begin
        start_i = 1'b1;
        dim_n_i = '0;
        dim_k_i = '0;
        dim_m_i = '0;
      end else if (poke && (cnt == 3 || cnt == MD + 4)) begin
        start_i = 1'b0;
      end
      if (res_we_o) begin
        writes++;
        if (!seen) begin
          seen = 1'b1;
          checkOutput("first_write_latency", 64'(cnt), 64'(MD + 3));
        end
      end
      if (reset_after > 0 && writes == reset_after) begin
        #2;
        rst_ni = 1'b0;
        #1;
        checkOutput("reset_ctrl_outputs", 64'({res_we_o, busy_o, done_o, op_start_o, ovf_o}), 64'(0));
        checkOutput("reset_res_data", res_data_o, 64'(0));
        checkOutput("reset_res_addr", 64'(res_addr_o), 64'(0));
        exp_q.delete();
        start_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_ni = 1'b1;
        checkOutput("no_done_after_reset", 64'(done_cnt), 64'(done_before));
        return;
      end
      if (done_o) begin
        checkOutput("done_latency", 64'(cnt), 64'(MD + nm + 2));
        break;
      end
      if (cnt > 200) begin
        checkOutput("job_timeout", 64'(cnt), 64'(MD + nm + 2));
        exp_q.delete();
        return;
      end
    end
    #2;
    checkOutput("write_count", 64'(writes), 64'(nm));
    checkOutput("single_done", 64'(done_cnt), 64'(done_before + 1));
    checkOutput("ovf_flag", 64'(ovf_o), 64'(exp_ovf));
  endtask

  // Monitor: pops the scoreboard on every write and checks done alignment.
  initial begin
    bit last_popped;
    exp_t e;
    forever begin
      @(negedge clk_i);
      last_popped = 1'b0;
      if (rst_ni) begin
        if (res_we_o) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_write", 64'(res_we_o), 64'(0));
          end else begin
            e = exp_q.pop_front();
            last_popped = e.last;
            checkOutput("wr_addr", 64'(res_addr_o), 64'(e.addr));
            checkOutput("wr_data", res_data_o, e.data);
          end
        end
        if (done_o) begin
          done_cnt++;
          checkOutput("done_with_last_write", 64'(res_we_o && last_popped), 64'(1));
        end
      end
    end
  end

  initial begin
    for (int r = 0; r < MD; r++)
      for (int c = 0; c < MD; c++) begin
        a_mem[r][c] = '0;
        b_mem[r][c] = '0;
      end

    #1;
    checkOutput("reset_ctrl_outputs", 64'({res_we_o, busy_o, done_o, op_start_o, ovf_o}), 64'(0));
    checkOutput("reset_res_data", res_data_o, 64'(0));
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] basic 2x2 multiply");
    a_mem[0][0] = 1; a_mem[0][1] = 2; a_mem[1][0] = 3; a_mem[1][1] = 4;
    b_mem[0][0] = 5; b_mem[0][1] = 6; b_mem[1][0] = 7; b_mem[1][1] = 8;
    applyStimulus(1, 1, 1, 1'b0, 1'b0, 0);

    $display("[TB] k masking");
    applyStimulus(1, 0, 1, 1'b0, 1'b0, 0);

    $display("[TB] negative extremes and overflow");
    a_mem[0][0] = 32'h8000_0000; a_mem[0][1] = 32'h8000_0000;
    b_mem[0][0] = 32'h8000_0000; b_mem[1][0] = 32'h8000_0000;
    applyStimulus(0, 1, 0, 1'b0, 1'b0, 0);
    repeat (3) @(negedge clk_i);
    checkOutput("ovf_sticky", 64'(ovf_o), 64'(1));

    $display("[TB] start while busy");
    fillRandom();
    applyStimulus(1, 1, 1, 1'b0, 1'b1, 0);

    $display("[TB] reset mid-calc");
    fillRandom();
    applyStimulus(1, 1, 1, 1'b0, 1'b0, 2);
    applyStimulus(1, 1, 1, 1'b0, 1'b0, 0);

    $display("[TB] back-to-back minimal job");
    fillRandom();
    applyStimulus(0, 0, 0, 1'b1, 1'b0, 0);

    $display("[TB] randomized jobs");
    for (int t = 0; t < 12; t++) begin
      fillRandom();
      applyStimulus(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 1)), bit'(t % 2), 1'b0, 0);
    end

    repeat (5) @(negedge clk_i);
    checkOutput("idle_after_jobs", 64'(busy_o), 64'(0));
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
